// File: rtl/avalon_ram_burst_reader.sv
// Avalon-MM burst reader: fetches DEPTH words from an on-chip RAM port and emits them as one
// Avalon-ST packet through a credit-limited FIFO. Optional macro CHECKSUM_EN adds a running checksum port.
module avalon_ram_burst_reader #(
  parameter int ADDR_W       = 2,
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 4,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata,
  output logic [DATA_W-1:0]   st_data,
  output logic                st_valid,
  input  logic                st_ready,
  output logic                st_sop,
`ifdef CHECKSUM_EN
  output logic [DATA_W-1:0]   checksum,
`endif
  output logic                st_eop
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(FIFO_DEPTH + 1) + 1;
  localparam logic [CW-1:0] LAST_C = CW'(DEPTH - 1);
  localparam logic [OW-1:0] FIFO_DEPTH_C = OW'(FIFO_DEPTH);

  // Handshakes: an Avalon-MM read is accepted when avm_read & !avm_waitrequest; a stream word
  // moves when st_valid & st_ready. Both sides hold address/data stable while stalled.
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]             accept_cnt_q, accept_cnt_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [READ_LATENCY-1:0]   pipe_q, pipe_d;
  logic [DATA_W-1:0]         fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]             fifo_cnt_q, fifo_cnt_d;
  logic [OW-1:0]             in_flight, occupancy;
  logic                      rd_req, rd_acc, push, pop, fifo_full;
`ifdef CHECKSUM_EN
  logic [DATA_W-1:0]         chk_q, chk_d;
`endif

  assign push      = pipe_q[READ_LATENCY-1];
  assign st_valid  = (fifo_cnt_q != '0);
  assign pop       = st_valid & st_ready;
  assign fifo_full = (fifo_cnt_q == FIFO_DEPTH_C);
  assign rd_acc    = rd_req & ~avm_waitrequest;

  always_comb begin
    state_d      = state_q;
    issue_cnt_d  = issue_cnt_q;
    accept_cnt_d = accept_cnt_q;
    addr_d       = addr_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_cnt_d   = fifo_cnt_q;
    rd_req       = 1'b0;
    in_flight    = '0;
    for (int i = 0; i < READ_LATENCY; i++) in_flight = in_flight + OW'(pipe_q[i]);
    // Every accepted read owns a FIFO slot from issue until it is popped.
    occupancy = fifo_cnt_q + in_flight;

    case (state_q)
      S_IDLE: begin
        addr_d = '0;
        if (start) begin
          state_d      = S_ISSUE;
          issue_cnt_d  = '0;
          accept_cnt_d = '0;
        end
      end
      S_ISSUE: begin
        rd_req = (occupancy < FIFO_DEPTH_C);
        if (rd_acc) begin
          addr_d      = addr_q + 1'b1;
          issue_cnt_d = issue_cnt_q + 1'b1;
          if (issue_cnt_q == LAST_C) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && accept_cnt_q == LAST_C) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    pipe_d[0] = rd_acc;
    for (int i = 1; i < READ_LATENCY; i++) pipe_d[i] = pipe_q[i-1];

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d     = rd_ptr_q + 1'b1;
      accept_cnt_d = accept_cnt_d + 1'b1;
    end
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

`ifdef CHECKSUM_EN
  always_comb begin
    chk_d = chk_q;
    if (state_q == S_IDLE && start) chk_d = '0;
    else if (pop)                   chk_d = chk_q + st_data;
  end
  assign checksum = chk_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      issue_cnt_q  <= '0;
      accept_cnt_q <= '0;
      addr_q       <= '0;
      pipe_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
`ifdef CHECKSUM_EN
      chk_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      issue_cnt_q  <= issue_cnt_d;
      accept_cnt_q <= accept_cnt_d;
      addr_q       <= addr_d;
      pipe_q       <= pipe_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
`ifdef CHECKSUM_EN
      chk_q        <= chk_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= avm_readdata;
  end

`ifndef SYNTHESIS
  // Push into a full FIFO is only legal when a pop frees a slot in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) assert (!(push && fifo_full && !pop));
  end
`endif

  assign avm_read       = rd_req;
  assign avm_address    = addr_q;
  assign avm_byteenable = '1;
  assign busy           = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done           = (state_q == S_DONE);
  assign st_data        = fifo_mem_q[rd_ptr_q];
  assign st_sop         = st_valid && (accept_cnt_q == '0);
  assign st_eop         = st_valid && (accept_cnt_q == LAST_C);

endmodule

// File: tb/tb_avalon_ram_burst_reader.sv
// Directed bench for avalon_ram_burst_reader: one instance with READ_LATENCY=1 and one with 3,
// each fed by a small fixed-latency RAM model; a vector table drives whole-packet scenarios.
module tb_avalon_ram_burst_reader;
  localparam int DW = 32;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic start_drv, ready_drv, wait_drv, sel;

  logic          start1, wait1, busy1, done1, read1, valid1, sop1, eop1;
  logic [AW-1:0] addr1;
  logic [3:0]    be1;
  logic [DW-1:0] rdata1, data1;
  logic          start3, wait3, busy3, done3, read3, valid3, sop3, eop3;
  logic [AW-1:0] addr3;
  logic [3:0]    be3;
  logic [DW-1:0] rdata3, data3;
`ifdef CHECKSUM_EN
  logic [DW-1:0] chk1, chk3;
`endif

  assign start1 = !sel && start_drv;
  assign start3 = sel && start_drv;
  assign wait1  = !sel && wait_drv;
  assign wait3  = sel && wait_drv;

  avalon_ram_burst_reader #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(4), .READ_LATENCY(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
    .avm_address(addr1), .avm_read(read1), .avm_byteenable(be1), .avm_waitrequest(wait1),
    .avm_readdata(rdata1), .st_data(data1), .st_valid(valid1), .st_ready(ready_drv),
    .st_sop(sop1),
`ifdef CHECKSUM_EN
    .checksum(chk1),
`endif
    .st_eop(eop1));

  avalon_ram_burst_reader #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(4), .READ_LATENCY(3), .FIFO_DEPTH(4)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .busy(busy3), .done(done3),
    .avm_address(addr3), .avm_read(read3), .avm_byteenable(be3), .avm_waitrequest(wait3),
    .avm_readdata(rdata3), .st_data(data3), .st_valid(valid3), .st_ready(ready_drv),
    .st_sop(sop3),
`ifdef CHECKSUM_EN
    .checksum(chk3),
`endif
    .st_eop(eop3));

  logic          busy_m, done_m, read_m, valid_m, sop_m, eop_m;
  logic [AW-1:0] addr_m;
  logic [DW-1:0] data_m;
  assign busy_m  = sel ? busy3  : busy1;
  assign done_m  = sel ? done3  : done1;
  assign read_m  = sel ? read3  : read1;
  assign valid_m = sel ? valid3 : valid1;
  assign sop_m   = sel ? sop3   : sop1;
  assign eop_m   = sel ? eop3   : eop1;
  assign addr_m  = sel ? addr3  : addr1;
  assign data_m  = sel ? data3  : data1;

  // RAM models: data is only meaningful READ_LATENCY cycles after an accepted read.
  logic [DW-1:0] ram [4];
  logic [DW-1:0] rd1_q;
  logic [DW-1:0] rd3_q [3];
  always @(posedge clk) begin
    rd1_q    <= (read1 && !wait1) ? ram[addr1] : 32'hDEAD_BEEF;
    rd3_q[0] <= (read3 && !wait3) ? ram[addr3] : 32'hDEAD_BEEF;
    rd3_q[1] <= rd3_q[0];
    rd3_q[2] <= rd3_q[1];
  end
  assign rdata1 = rd1_q;
  assign rdata3 = rd3_q[2];

  typedef struct {
    bit lat3;
    int mode;        // 0: ready always, 1: ready on odd cycles, 2: ready low for cycles 1..10
    int wait_addr;
    int wait_cycles;
    int extra_start; // cycle of a second start pulse, 0 = none
    int exp_first;   // cycle of first stream transfer (start is cycle 0)
    int exp_done;    // cycle of the done pulse
  } vec_t;
  vec_t vecs [9];

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic ready_for(input int mode, input int cyc);
    case (mode)
      0:       return cyc > 0;
      1:       return (cyc % 2) == 1;
      default: return cyc > 10;
    endcase
  endfunction

  task automatic run_packet(input vec_t v);
    int cyc, ndone, done_cyc, first_cyc, nwords, nreads, max_out, wait_left, tail;
    logic [DW-1:0] exp_w;
    cyc = 0; ndone = 0; done_cyc = -1; first_cyc = -1; nwords = 0; nreads = 0;
    max_out = 0; tail = 0; wait_left = v.wait_cycles;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(ram[i]);
    @(posedge clk); #1;
    sel = v.lat3; start_drv = 1'b1; ready_drv = 1'b0; wait_drv = 1'b0;
    while (cyc < 80 && tail < 4) begin
      @(negedge clk);
      if (cyc == 1) check("busy_after_start", 32'(busy_m), 32'd1);
      if (read_m && !wait_drv) nreads++;
      if (wait_drv) begin
        check("wait_addr_held", 32'(addr_m), 32'(v.wait_addr));
        check("wait_read_held", 32'(read_m), 32'd1);
      end
      if (valid_m && ready_drv) begin
        if (nwords == 0) first_cyc = cyc;
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0_BAD0;
        check("st_data", data_m, exp_w);
        check("st_sop", 32'(sop_m), 32'(nwords == 0));
        check("st_eop", 32'(eop_m), 32'(nwords == 3));
        nwords++;
      end
      if (nreads - nwords > max_out) max_out = nreads - nwords;
      if (done_m) begin
        ndone++;
        if (ndone == 1) done_cyc = cyc;
        check("busy_in_done", 32'(busy_m), 32'd0);
      end else if (ndone > 0) begin
        tail++;
        check("tail_busy", 32'(busy_m), 32'd0);
        check("tail_valid", 32'(valid_m), 32'd0);
        check("tail_read", 32'(read_m), 32'd0);
      end
      @(posedge clk); #1;
      cyc++;
      start_drv = (cyc == v.extra_start);
      ready_drv = ready_for(v.mode, cyc);
      if (read_m && addr_m == AW'(v.wait_addr) && wait_left > 0) begin
        wait_drv = 1'b1;
        wait_left--;
      end else begin
        wait_drv = 1'b0;
      end
    end
    check("done_pulses", 32'(ndone), 32'd1);
    check("done_cycle", 32'(done_cyc), 32'(v.exp_done));
    check("first_xfer_cycle", 32'(first_cyc), 32'(v.exp_first));
    check("words_out", 32'(nwords), 32'd4);
    check("reads_issued", 32'(nreads), 32'd4);
    check("max_outstanding_le_4", 32'(max_out <= 4), 32'd1);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
`ifdef CHECKSUM_EN
    check("checksum", sel ? chk3 : chk1, 32'hAAAA_AAAA);
`endif
    ready_drv = 1'b0;
    wait_drv  = 1'b0;
  endtask

  initial begin
    int nxfer, nd;
    ram[0] = 32'h1111_1111; ram[1] = 32'h2222_2222;
    ram[2] = 32'h3333_3333; ram[3] = 32'h4444_4444;
    //           lat3 mode waddr wcyc extra first done
    vecs[0] = '{1'b0, 0,   0,    0,   0,    3,    7};
    vecs[1] = '{1'b0, 2,   0,    0,   0,    11,   15};
    vecs[2] = '{1'b0, 1,   0,    0,   0,    3,    10};
    vecs[3] = '{1'b0, 0,   2,    3,   0,    3,    10};
    vecs[4] = '{1'b0, 0,   0,    0,   4,    3,    7};
    vecs[5] = '{1'b0, 0,   0,    0,   7,    3,    7};
    vecs[6] = '{1'b1, 0,   0,    0,   0,    5,    9};
    vecs[7] = '{1'b1, 1,   0,    0,   0,    5,    12};
    vecs[8] = '{1'b1, 2,   0,    0,   0,    11,   15};

    reset = 1'b1; start_drv = 1'b0; ready_drv = 1'b0; wait_drv = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_read", 32'(read1), 32'd0);
    check("rst_addr", 32'(addr1), 32'd0);
    check("rst_valid", 32'(valid1), 32'd0);
    check("rst_sop", 32'(sop1), 32'd0);
    check("rst_eop", 32'(eop1), 32'd0);
    check("rst_busy3", 32'(busy3), 32'd0);
    check("byteenable", 32'(be1), 32'hF);
    check("byteenable3", 32'(be3), 32'hF);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 9; i++) run_packet(vecs[i]);

    // Reset after two words have been transferred.
    @(posedge clk); #1;
    sel = 1'b0; start_drv = 1'b1; ready_drv = 1'b1;
    nxfer = 0;
    for (int c = 0; c < 20 && nxfer < 2; c++) begin
      @(negedge clk);
      if (valid1 && ready_drv) nxfer++;
      @(posedge clk); #1;
      start_drv = 1'b0;
    end
    check("mid_words_before_reset", 32'(nxfer), 32'd2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy1), 32'd0);
    check("mid_rst_valid", 32'(valid1), 32'd0);
    check("mid_rst_read", 32'(read1), 32'd0);
    check("mid_rst_addr", 32'(addr1), 32'd0);
    nd = 0;
    for (int c = 0; c < 8; c++) begin
      if (done1) nd++;
      if (valid1) nd++;
      @(negedge clk);
    end
    check("mid_rst_no_done_no_data", 32'(nd), 32'd0);
    run_packet(vecs[0]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
